// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory arbiter slice.
package dmem_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 5;

    // Requester identifiers as carried in the response register.
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The pointer remembers the port served last;
// on contention the other port wins. Resets pointing at port 1 so port 0
// gets first priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant;

    // Lone requester wins outright; on contention the port not served last wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Pointer follows every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|gnt) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer for the single-port 32-word data memory. Port 0 is the
// core load/store path, port 1 the program/debug loader. One access is granted
// per cycle; its response (load data, store ack or misalignment error) is
// returned to the issuing port exactly one cycle later.
//
// Response register states:
//   state | meaning
//   IDLE  | rsp_pend=0, no response due this cycle
//   RESP  | rsp_pend=1, response due on port rsp_id; a new grant may overlap
module dmem_arbiter #(
    parameter int ADDR_W     = dmem_pkg::ADDR_W,
    parameter int DATA_W     = dmem_pkg::DATA_W,
    parameter int DEPTH_LOG2 = dmem_pkg::DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [ADDR_W-1:0]     r0_addr,
    input  logic [DATA_W-1:0]     r0_wdata,
    output logic                  r0_rvalid,
    output logic [DATA_W-1:0]     r0_rdata,
    output logic                  r0_err,

    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [ADDR_W-1:0]     r1_addr,
    input  logic [DATA_W-1:0]     r1_wdata,
    output logic                  r1_rvalid,
    output logic [DATA_W-1:0]     r1_rdata,
    output logic                  r1_err,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    import dmem_pkg::*;

    logic [1:0]            gnt;
    logic                  gnt_any;
    logic                  gnt_id;

    logic                  sel_we;
    logic [1:0]            sel_lsb;
    logic [DEPTH_LOG2-1:0] sel_word;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  sel_mis;

    logic                  rsp_pend;
    logic                  rsp_id;
    logic                  rsp_we;
    logic                  rsp_err;
    logic [DATA_W-1:0]     rsp_data;

    // Upper address bits only select a wrapped alias of the same word.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{r0_addr[ADDR_W-1:DEPTH_LOG2+2], r1_addr[ADDR_W-1:DEPTH_LOG2+2]};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({r1_valid, r0_valid}),
        .gnt (gnt)
    );

    assign gnt_any  = |gnt;
    assign gnt_id   = gnt[1];
    assign r0_ready = gnt[0];
    assign r1_ready = gnt[1];

    // Steer the granted request onto the memory port; misaligned requests are
    // accepted but never reach the memory.
    always_comb begin
        sel_we    = gnt_id ? r1_we    : r0_we;
        sel_lsb   = gnt_id ? r1_addr[1:0] : r0_addr[1:0];
        sel_word  = gnt_id ? r1_addr[DEPTH_LOG2+1:2] : r0_addr[DEPTH_LOG2+1:2];
        sel_wdata = gnt_id ? r1_wdata : r0_wdata;
        sel_mis   = addr_misaligned(sel_lsb);

        mem_en    = gnt_any & ~sel_mis;
        mem_we    = gnt_any & ~sel_mis & sel_we;
        mem_addr  = sel_word;
        mem_wdata = sel_wdata;
    end

    // Capture the accepted request so its response can be routed next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_pend <= 1'b0;
            rsp_id   <= PORT_CORE;
            rsp_we   <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            rsp_pend <= gnt_any;
            if (gnt_any) begin
                rsp_id  <= gnt_id;
                rsp_we  <= sel_we;
                rsp_err <= sel_mis;
            end
        end
    end

    // Route the response to the issuing port; only loads pass memory data.
    always_comb begin
        rsp_data  = (rsp_we || rsp_err) ? '0 : mem_rdata;

        r0_rvalid = rsp_pend && (rsp_id == PORT_CORE);
        r1_rvalid = rsp_pend && (rsp_id == PORT_LOAD);
        r0_err    = r0_rvalid && rsp_err;
        r1_err    = r1_rvalid && rsp_err;
        r0_rdata  = r0_rvalid ? rsp_data : '0;
        r1_rdata  = r1_rvalid ? rsp_data : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter. A synchronous 32-word
// memory sits on the memory port; expectations come from a word-level model
// that serialises accepted requests in grant order.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        r0_valid, r0_ready, r0_we, r0_rvalid, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_we, r1_rvalid, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int errors;
    int checks;

    // Memory environment
    logic [31:0] mem [32];

    // Reference model state
    logic [31:0] ref_mem [32];
    int          exp_last;
    logic        pend_v;
    int          pend_p;
    logic        pend_e;
    logic [31:0] pend_d;
    logic        exp_g0, exp_g1;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r0_err    (r0_err),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .r1_err    (r1_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive both requesters, check at the falling edge, then
    // advance the model by whatever was accepted.
    task automatic cycle(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        int          gp;
        logic [31:0] ga, gd;
        logic        gw, mis;
        int          word;
        r0_valid = v0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
        @(negedge clk);

        chk("r0_rvalid", {31'b0, r0_rvalid}, {31'b0, pend_v && pend_p == 0});
        chk("r1_rvalid", {31'b0, r1_rvalid}, {31'b0, pend_v && pend_p == 1});
        chk("r0_err",    {31'b0, r0_err},    {31'b0, pend_v && pend_p == 0 && pend_e});
        chk("r1_err",    {31'b0, r1_err},    {31'b0, pend_v && pend_p == 1 && pend_e});
        chk("r0_rdata",  r0_rdata, (pend_v && pend_p == 0) ? pend_d : 32'h0);
        chk("r1_rdata",  r1_rdata, (pend_v && pend_p == 1) ? pend_d : 32'h0);

        if (v0 && v1)  gp = 1 - exp_last;
        else if (v0)   gp = 0;
        else if (v1)   gp = 1;
        else           gp = -1;
        exp_g0 = (gp == 0);
        exp_g1 = (gp == 1);
        chk("r0_ready", {31'b0, r0_ready}, {31'b0, exp_g0});
        chk("r1_ready", {31'b0, r1_ready}, {31'b0, exp_g1});

        pend_v = 1'b0;
        if (gp >= 0) begin
            ga   = (gp == 0) ? a0 : a1;
            gd   = (gp == 0) ? d0 : d1;
            gw   = (gp == 0) ? w0 : w1;
            mis  = (ga % 4) != 0;
            word = (ga / 4) % 32;
            chk("mem_en", {31'b0, mem_en}, {31'b0, !mis});
            if (!mis) begin
                chk("mem_we",   {31'b0, mem_we}, {31'b0, gw});
                chk("mem_addr", {27'b0, mem_addr}, word);
                if (gw) chk("mem_wdata", mem_wdata, gd);
            end
            pend_v = 1'b1;
            pend_p = gp;
            pend_e = mis;
            if (mis)     pend_d = 32'h0;
            else if (gw) begin pend_d = 32'h0; ref_mem[word] = gd; end
            else         pend_d = ref_mem[word];
            exp_last = gp;
        end else begin
            chk("mem_en_idle", {31'b0, mem_en}, 32'h0);
        end

        @(posedge clk);
        #1;
    endtask

    logic        h0v, h0w, h1v, h1w;
    logic [31:0] h0a, h0d, h1a, h1d;

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem_rdata = 32'h0;
        exp_last  = 1;
        pend_v    = 1'b0;
        pend_p    = 0;
        pend_e    = 1'b0;
        pend_d    = 32'h0;

        // Reset state
        rst = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Store then load at word 2
        cycle(1, 1, 32'h08, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle(1, 0, 32'h08, 32'h0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("dir_load_0x08", ref_mem[2], 32'hDEADBEEF);

        // Contention: both valid for 4 cycles, grants alternate
        mem[1] = 32'h1111_0001;  ref_mem[1] = 32'h1111_0001;
        mem[3] = 32'h3333_0003;  ref_mem[3] = 32'h3333_0003;
        for (int i = 0; i < 4; i++) cycle(1, 0, 32'h04, 0, 1, 0, 32'h0C, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Misaligned loader request
        cycle(0, 0, 0, 0, 1, 0, 32'h0A, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Wrapped store from loader, immediate load from core
        cycle(0, 0, 0, 0, 1, 1, 32'h84, 32'h12345678);
        cycle(1, 0, 32'h04, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the cycle after a grant drops the pending response
        cycle(1, 0, 32'h08, 0, 0, 0, 0, 0);
        rst    = 1'b1;
        pend_v = 1'b0;
        exp_last = 1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 32'h08, 0, 1, 0, 32'h0C, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic; an ungranted request is held unchanged
        h0v = 0; h0w = 0; h0a = 0; h0d = 0;
        h1v = 0; h1w = 0; h1a = 0; h1d = 0;
        exp_g0 = 0; exp_g1 = 0;
        for (int n = 0; n < 400; n++) begin
            if (!(h0v && !exp_g0)) begin
                h0v = ($urandom_range(0, 9) < 7);
                h0w = $urandom_range(0, 1);
                h0a = $urandom;
                h0a[6:5] = 2'b00;
                if ($urandom_range(0, 7) != 0) h0a[1:0] = 2'b00;
                h0d = $urandom;
            end
            if (!(h1v && !exp_g1)) begin
                h1v = ($urandom_range(0, 9) < 7);
                h1w = $urandom_range(0, 1);
                h1a = $urandom;
                h1a[6:5] = 2'b00;
                if ($urandom_range(0, 7) != 0) h1a[1:0] = 2'b00;
                h1d = $urandom;
            end
            cycle(h0v, h0w, h0a, h0d, h1v, h1w, h1a, h1d);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
